// File: rtl/mem_arb_pkg.sv
// Shared types for the MIPS150 memory-port arbiter.
//   state_e : arbiter FSM states
//   owner_e : which requester owns the outstanding transaction
//   SZ_*    : DM size codes, same 2-bit encoding as the decoder's MemWrite
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_LOAD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

endpackage

// File: rtl/store_lane_gen.sv
// Combinational big-endian store lane generator.
//   i_size    : SZ_LOAD / SZ_BYTE / SZ_HALF / SZ_WORD
//   i_addr_lo : byte offset addr[1:0]
//   i_wdata   : right-justified store data
//   o_we      : byte enables, o_we[3] covers bits 31:24 (byte offset 0)
//   o_wdata   : store data replicated across all lanes
//   o_misalign: halfword/word store not naturally aligned (o_we forced to 0)
module store_lane_gen
  import mem_arb_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata,
  output logic        o_misalign
);

  always_comb begin
    o_we       = 4'b0000;
    o_wdata    = i_wdata;
    o_misalign = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_we    = 4'b1000 >> i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_addr_lo[0];
        if (!i_addr_lo[0]) begin
          o_we = i_addr_lo[1] ? 4'b0011 : 4'b1100;
        end
      end
      SZ_WORD: begin
        o_misalign = (i_addr_lo != 2'b00);
        if (i_addr_lo == 2'b00) begin
          o_we = 4'b1111;
        end
      end
      default: begin
        o_we = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter between instruction fetch (IF) and data memory (DM).
// One outstanding transaction at a time; DM has priority, but IF is forced through
// after STARVE_LIMIT consecutive DM grants while it waits (0 = strict DM priority).
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_if_req/i_if_addr            fetch request, held until o_if_gnt
//   o_if_gnt/o_if_rvalid/o_if_rdata  grant pulse, data-valid pulse, fetched word
//   i_dm_req/i_dm_addr/i_dm_size/i_dm_wdata  data request (size 00 ld,01 sb,10 sh,11 sw)
//   o_dm_gnt/o_dm_rvalid/o_dm_rdata/o_dm_err completion; err flags misaligned store
//   o_mem_req/o_mem_addr/o_mem_we/o_mem_wdata  request to memory, word-aligned
//   i_mem_ready/i_mem_rvalid/i_mem_rdata       memory accept / response
//
// Optional: define MEM_ARB_PERF_EN to add o_perf_conflict and o_perf_if_wait counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_dm_req,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [1:0]        i_dm_size,
  input  logic [31:0]       i_dm_wdata,
  output logic              o_dm_gnt,
  output logic              o_dm_rvalid,
  output logic [31:0]       o_dm_rdata,
  output logic              o_dm_err,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]       o_perf_conflict,
  output logic [31:0]       o_perf_if_wait,
`endif
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_we,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata
);

  state_e            r_state;
  owner_e            r_owner;
  logic [31:0]       r_starve_cnt;
  logic              r_misalign;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_we;
  logic [31:0]       r_mem_wdata;
  logic              r_if_rvalid;
  logic [31:0]       r_if_rdata;
  logic              r_dm_rvalid;
  logic [31:0]       r_dm_rdata;
  logic              r_dm_err;

  logic [3:0]        w_lane_we;
  logic [31:0]       w_lane_wdata;
  logic              w_lane_misalign;
  logic              w_if_win;
  logic              w_idle;
  logic              w_if_gnt;
  logic              w_dm_gnt;
  logic [1:0]        w_unused_if_addr_lo;

  // Fetches are always word-aligned; the byte offset is deliberately dropped.
  assign w_unused_if_addr_lo = i_if_addr[1:0];

  store_lane_gen u_store_lane_gen (
    .i_size     (i_dm_size),
    .i_addr_lo  (i_dm_addr[1:0]),
    .i_wdata    (i_dm_wdata),
    .o_we       (w_lane_we),
    .o_wdata    (w_lane_wdata),
    .o_misalign (w_lane_misalign)
  );

  always_comb begin
    w_if_win = 1'b0;
    if (i_if_req) begin
      if (!i_dm_req) begin
        w_if_win = 1'b1;
      end else if ((STARVE_LIMIT != 0) && (r_starve_cnt >= STARVE_LIMIT)) begin
        w_if_win = 1'b1;
      end
    end
  end

  // Grants are combinational so the requester sees them in the request cycle;
  // masked during reset because the FSM will not latch anything that cycle.
  assign w_idle   = (r_state == ST_IDLE) && !i_rst;
  assign w_if_gnt = w_idle && w_if_win;
  assign w_dm_gnt = w_idle && i_dm_req && !w_if_win;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_IF;
      r_starve_cnt <= '0;
      r_misalign   <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_we     <= 4'b0000;
      r_mem_wdata  <= '0;
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= '0;
      r_dm_rvalid  <= 1'b0;
      r_dm_rdata   <= '0;
      r_dm_err     <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_dm_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_if_gnt) begin
            r_owner      <= OWN_IF;
            r_mem_addr   <= {i_if_addr[ADDR_W-1:2], 2'b00};
            r_mem_we     <= 4'b0000;
            r_mem_wdata  <= '0;
            r_misalign   <= 1'b0;
            r_mem_req    <= 1'b1;
            r_starve_cnt <= '0;
            r_state      <= ST_REQ;
          end else if (w_dm_gnt) begin
            r_owner     <= OWN_DM;
            r_mem_addr  <= {i_dm_addr[ADDR_W-1:2], 2'b00};
            r_mem_we    <= w_lane_we;
            r_mem_wdata <= w_lane_wdata;
            r_misalign  <= w_lane_misalign;
            r_mem_req   <= 1'b1;
            r_state     <= ST_REQ;
            if (!i_if_req) begin
              r_starve_cnt <= '0;
            end else if (r_starve_cnt < STARVE_LIMIT) begin
              r_starve_cnt <= r_starve_cnt + 32'd1;
            end
          end else if (!i_if_req) begin
            r_starve_cnt <= '0;
          end
        end
        ST_REQ: begin
          if (i_mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_mem_rvalid) begin
            if (r_owner == OWN_IF) begin
              r_if_rdata  <= i_mem_rdata;
              r_if_rvalid <= 1'b1;
            end else begin
              r_dm_rdata  <= i_mem_rdata;
              r_dm_rvalid <= 1'b1;
              r_dm_err    <= r_misalign;
            end
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_conflict;
  logic [31:0] r_perf_if_wait;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_conflict <= '0;
      r_perf_if_wait  <= '0;
    end else begin
      if ((r_state == ST_IDLE) && i_if_req && i_dm_req) begin
        r_perf_conflict <= r_perf_conflict + 32'd1;
      end
      if (i_if_req && !w_if_gnt) begin
        r_perf_if_wait <= r_perf_if_wait + 32'd1;
      end
    end
  end

  assign o_perf_conflict = r_perf_conflict;
  assign o_perf_if_wait  = r_perf_if_wait;
`endif

  assign o_if_gnt    = w_if_gnt;
  assign o_dm_gnt    = w_dm_gnt;
  assign o_if_rvalid = r_if_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rvalid = r_dm_rvalid;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_dm_err    = r_dm_err;
  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_we    = r_mem_we;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// u_dut uses STARVE_LIMIT=4 with a bench-driven memory; u_dut0 uses STARVE_LIMIT=0
// with an always-ready, one-cycle-latency memory and shares the request inputs.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [1:0]  dm_size;
  logic [31:0] dm_wdata;
  logic        man_ready, man_rvalid;
  logic [31:0] man_rdata;
  logic        auto_mode;
  logic        auto_rv = 1'b0;
  logic        auto_rv0 = 1'b0;

  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_err, mem_req;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic        mem_ready, mem_rvalid;

  logic        if_gnt0, dm_gnt0, mem_req0;
  logic        unused_if_rvalid0, unused_dm_rvalid0, unused_dm_err0;
  logic [31:0] unused_if_rdata0, unused_dm_rdata0, unused_mem_addr0, unused_mem_wdata0;
  logic [3:0]  unused_mem_we0;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_conflict, perf_if_wait, unused_pc0, unused_pw0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign mem_ready  = auto_mode ? 1'b1 : man_ready;
  assign mem_rvalid = auto_mode ? auto_rv : man_rvalid;

  // Auto memory: accept immediately, respond the cycle after acceptance.
  always @(posedge clk) auto_rv  <= mem_req & mem_ready;
  always @(posedge clk) auto_rv0 <= mem_req0;

  mem_port_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) u_dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_if_req        (if_req),
    .i_if_addr       (if_addr),
    .o_if_gnt        (if_gnt),
    .o_if_rvalid     (if_rvalid),
    .o_if_rdata      (if_rdata),
    .i_dm_req        (dm_req),
    .i_dm_addr       (dm_addr),
    .i_dm_size       (dm_size),
    .i_dm_wdata      (dm_wdata),
    .o_dm_gnt        (dm_gnt),
    .o_dm_rvalid     (dm_rvalid),
    .o_dm_rdata      (dm_rdata),
    .o_dm_err        (dm_err),
`ifdef MEM_ARB_PERF_EN
    .o_perf_conflict (perf_conflict),
    .o_perf_if_wait  (perf_if_wait),
`endif
    .o_mem_req       (mem_req),
    .o_mem_addr      (mem_addr),
    .o_mem_we        (mem_we),
    .o_mem_wdata     (mem_wdata),
    .i_mem_ready     (mem_ready),
    .i_mem_rvalid    (mem_rvalid),
    .i_mem_rdata     (man_rdata)
  );

  mem_port_arbiter #(.STARVE_LIMIT(0), .ADDR_W(32)) u_dut0 (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_if_req        (if_req),
    .i_if_addr       (if_addr),
    .o_if_gnt        (if_gnt0),
    .o_if_rvalid     (unused_if_rvalid0),
    .o_if_rdata      (unused_if_rdata0),
    .i_dm_req        (dm_req),
    .i_dm_addr       (dm_addr),
    .i_dm_size       (dm_size),
    .i_dm_wdata      (dm_wdata),
    .o_dm_gnt        (dm_gnt0),
    .o_dm_rvalid     (unused_dm_rvalid0),
    .o_dm_rdata      (unused_dm_rdata0),
    .o_dm_err        (unused_dm_err0),
`ifdef MEM_ARB_PERF_EN
    .o_perf_conflict (unused_pc0),
    .o_perf_if_wait  (unused_pw0),
`endif
    .o_mem_req       (mem_req0),
    .o_mem_addr      (unused_mem_addr0),
    .o_mem_we        (unused_mem_we0),
    .o_mem_wdata     (unused_mem_wdata0),
    .i_mem_ready     (1'b1),
    .i_mem_rvalid    (auto_rv0),
    .i_mem_rdata     (man_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // One DM transaction from IDLE with the bench memory; ends at the start of an IDLE cycle.
  task automatic dm_txn(input string tag, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] exp_we,
                        input logic [31:0] exp_wd, input logic exp_err);
    dm_req = 1'b1; dm_addr = addr; dm_size = size; dm_wdata = wd;
    smp();
    check({tag, ".gnt"}, {31'b0, dm_gnt}, 32'd1);
    tick();
    dm_req = 1'b0; man_ready = 1'b1;
    smp();
    check({tag, ".req"}, {31'b0, mem_req}, 32'd1);
    check({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
    check({tag, ".we"}, {28'b0, mem_we}, {28'b0, exp_we});
    if (exp_we != 4'b0000) check({tag, ".wdata"}, mem_wdata, exp_wd);
    tick();
    man_ready = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h0BAD_F00D;
    tick();
    man_rvalid = 1'b0;
    smp();
    check({tag, ".rvalid"}, {31'b0, dm_rvalid}, 32'd1);
    check({tag, ".err"}, {31'b0, dm_err}, {31'b0, exp_err});
    check({tag, ".rdata"}, dm_rdata, 32'h0BAD_F00D);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".if_gnt"}, {31'b0, if_gnt}, 32'd0);
    check({tag, ".dm_gnt"}, {31'b0, dm_gnt}, 32'd0);
    check({tag, ".if_rvalid"}, {31'b0, if_rvalid}, 32'd0);
    check({tag, ".dm_rvalid"}, {31'b0, dm_rvalid}, 32'd0);
    check({tag, ".dm_err"}, {31'b0, dm_err}, 32'd0);
    check({tag, ".mem_req"}, {31'b0, mem_req}, 32'd0);
    check({tag, ".mem_addr"}, mem_addr, 32'd0);
    check({tag, ".mem_we"}, {28'b0, mem_we}, 32'd0);
    check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    check({tag, ".if_rdata"}, if_rdata, 32'd0);
    check({tag, ".dm_rdata"}, dm_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] seq [10];
    int n_g, n_if0, n_dm0;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_addr = '0;
    dm_size = 2'b00; dm_wdata = '0; man_ready = 1'b0; man_rvalid = 1'b0;
    man_rdata = '0; auto_mode = 1'b0;
    tick(); tick();
    smp();
    check_all_zero("reset");
    tick();
    rst = 1'b0;

    // Single fetch
    if_req = 1'b1; if_addr = 32'h100;
    smp();
    check("fetch.if_gnt", {31'b0, if_gnt}, 32'd1);
    check("fetch.dm_gnt", {31'b0, dm_gnt}, 32'd0);
    tick();
    if_req = 1'b0; man_ready = 1'b1;
    smp();
    check("fetch.mem_req", {31'b0, mem_req}, 32'd1);
    check("fetch.mem_addr", mem_addr, 32'h100);
    check("fetch.mem_we", {28'b0, mem_we}, 32'd0);
    tick();
    man_ready = 1'b0;
    smp();
    check("fetch.req_drop", {31'b0, mem_req}, 32'd0);
    tick();
    man_rvalid = 1'b1; man_rdata = 32'h2402_000A;
    smp();
    check("fetch.no_early_rvalid", {31'b0, if_rvalid}, 32'd0);
    tick();
    man_rvalid = 1'b0;
    smp();
    check("fetch.if_rvalid", {31'b0, if_rvalid}, 32'd1);
    check("fetch.if_rdata", if_rdata, 32'h2402_000A);
    check("fetch.dm_rvalid", {31'b0, dm_rvalid}, 32'd0);
    tick();
    smp();
    check("fetch.rvalid_pulse", {31'b0, if_rvalid}, 32'd0);
    tick();

    // Simultaneous requests: DM first, IF at the next IDLE
    if_req = 1'b1; if_addr = 32'h100; dm_req = 1'b1; dm_addr = 32'h200; dm_size = 2'b00;
    smp();
    check("simul.dm_gnt", {31'b0, dm_gnt}, 32'd1);
    check("simul.if_gnt0", {31'b0, if_gnt}, 32'd0);
    tick();
    dm_req = 1'b0; man_ready = 1'b1;
    smp();
    check("simul.addr_dm", mem_addr, 32'h200);
    check("simul.if_gnt1", {31'b0, if_gnt}, 32'd0);
    tick();
    man_ready = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    tick();
    man_rvalid = 1'b0;
    smp();
    check("simul.dm_rvalid", {31'b0, dm_rvalid}, 32'd1);
    check("simul.dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    check("simul.if_gnt", {31'b0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0; man_ready = 1'b1;
    smp();
    check("simul.addr_if", mem_addr, 32'h100);
    tick();
    man_ready = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h1111_2222;
    tick();
    man_rvalid = 1'b0;
    smp();
    check("simul.if_rdata", if_rdata, 32'h1111_2222);
    check("simul.dm_rdata_hold", dm_rdata, 32'hDEAD_BEEF);
    tick();

    // Store lanes
    dm_txn("sb203", 2'b01, 32'h203, 32'h0000_00AB, 4'b0001, 32'hABAB_ABAB, 1'b0);
    dm_txn("sb200", 2'b01, 32'h200, 32'h0000_00C5, 4'b1000, 32'hC5C5_C5C5, 1'b0);
    dm_txn("sh202", 2'b10, 32'h202, 32'h0000_1234, 4'b0011, 32'h1234_1234, 1'b0);
    dm_txn("sh200", 2'b10, 32'h200, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 1'b0);
    dm_txn("sw204", 2'b11, 32'h204, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1'b0);
    dm_txn("sh201", 2'b10, 32'h201, 32'h0000_5678, 4'b0000, 32'h0, 1'b1);
    dm_txn("sw206", 2'b11, 32'h206, 32'h0102_0304, 4'b0000, 32'h0, 1'b1);
    dm_txn("ld208", 2'b00, 32'h208, 32'h0, 4'b0000, 32'h0, 1'b0);

    // Backpressure: payload must stay put while the DM inputs wander
    dm_req = 1'b1; dm_addr = 32'h300; dm_size = 2'b11; dm_wdata = 32'h55AA_55AA;
    tick();
    dm_req = 1'b0; dm_addr = 32'hFFFF_FFFF; dm_size = 2'b01; dm_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      smp();
      check("bp.req", {31'b0, mem_req}, 32'd1);
      check("bp.addr", mem_addr, 32'h300);
      check("bp.we", {28'b0, mem_we}, 32'hF);
      check("bp.wdata", mem_wdata, 32'h55AA_55AA);
      tick();
    end
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    // Now in WAIT: reset, then a stale response must be ignored
    rst = 1'b1;
    tick();
    rst = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h7777_7777;
    smp();
    check_all_zero("rst_wait");
    tick();
    man_rvalid = 1'b0;
    smp();
    check("rst.no_dm_rvalid", {31'b0, dm_rvalid}, 32'd0);
    check("rst.no_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    tick();
    if_req = 1'b1; if_addr = 32'h440;
    smp();
    check("rst.idle_gnt", {31'b0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0;

    // Starvation with an auto-responding memory
    rst = 1'b1; auto_mode = 1'b1;
    tick();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h100; dm_req = 1'b1; dm_addr = 32'h200; dm_size = 2'b00;
    n_g = 0; n_if0 = 0; n_dm0 = 0;
    for (int c = 0; c < 200 && n_g < 10; c++) begin
      smp();
      if (if_gnt0) n_if0++;
      if (dm_gnt0) n_dm0++;
      if (dm_gnt) begin seq[n_g] = 2'd1; n_g++; end
      else if (if_gnt) begin seq[n_g] = 2'd2; n_g++; end
    end
    check("starve.grants", n_g, 32'd10);
    for (int i = 0; i < n_g; i++) begin
      check($sformatf("starve.g%0d", i), {30'b0, seq[i]}, (i % 5 == 4) ? 32'd2 : 32'd1);
    end
    check("starve0.if_never", n_if0, 32'd0);
    check("starve0.dm_ran", {31'b0, n_dm0 >= 3}, 32'd1);
    tick();
    if_req = 1'b0; dm_req = 1'b0;
    tick(); tick(); tick();

    // Conflict cycles with IF dropping its request before being granted
    auto_mode = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h400; dm_size = 2'b00;
      smp();
      check($sformatf("conf%0d.dm_gnt", k), {31'b0, dm_gnt}, 32'd1);
      check($sformatf("conf%0d.if_gnt", k), {31'b0, if_gnt}, 32'd0);
      tick();
      if_req = 1'b0; dm_req = 1'b0; man_ready = 1'b1;
      tick();
      man_ready = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h4040_4040;
      tick();
      man_rvalid = 1'b0;
      smp();
      check($sformatf("conf%0d.if_rvalid", k), {31'b0, if_rvalid}, 32'd0);
      tick();
    end
`ifdef MEM_ARB_PERF_EN
    smp();
    check("perf.conflict", perf_conflict, 32'd3);
    check("perf.if_wait", perf_if_wait, 32'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    smp();
    check("perf.conflict_rst", perf_conflict, 32'd0);
    check("perf.if_wait_rst", perf_if_wait, 32'd0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single shared memory port between instruction fetch (IF) and the data-memory stage (DM) of the MIPS150 pipeline.
- Serialises the two requesters with one outstanding transaction at a time.
- Converts the DM store-size code (same 2-bit MemWrite encoding the decoder emits) into big-endian byte enables and lane-replicated write data.
- Sits between the pipeline datapath and the memory/cache controller; the datapath stalls on the gnt/rvalid handshakes.

Parameters:
- STARVE_LIMIT, 4: consecutive DM grants allowed while IF waits before IF is forced through; 0 = strict DM priority.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  one-cycle pulse; request latched
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  fetched word
- dm_req  in  1  data request; held until dm_gnt
- dm_addr  in  ADDR_W  data byte address
- dm_size  in  2  00 load, 01 SB, 10 SH, 11 SW
- dm_wdata  in  32  store data, right-justified
- dm_gnt  out  1  one-cycle pulse; request latched
- dm_rvalid  out  1  one-cycle pulse; completion (load data or store ack)
- dm_rdata  out  32  raw aligned word; lane select/extension is downstream
- dm_err  out  1  pulses with dm_rvalid on a misaligned store
- mem_req  out  1  request to memory
- mem_addr  out  ADDR_W  word-aligned address: {addr[ADDR_W-1:2],2'b00}
- mem_we  out  4  byte enables; we[3] = bits 31:24 = byte offset 0
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  memory accepts mem_req this cycle
- mem_rvalid  in  1  response/ack; at least 1 cycle after acceptance
- mem_rdata  in  32  response data

Behaviour:
- FSM states: IDLE, REQ, WAIT. Reset: state=IDLE; all outputs 0; starve counter 0.
- IDLE: if any request, choose a winner.
  - Winner rule: DM wins, unless (STARVE_LIMIT!=0 and if_req and starve_cnt>=STARVE_LIMIT), in which case IF wins.
  - Latch addr/we/wdata/owner into registers.
  - Pulse the winner's gnt in this cycle (combinational from state and reqs).
  - Next state REQ.
- REQ: mem_req=1 from registers. Hold mem_req and the payload stable until mem_ready; then go to WAIT with mem_req=0 next cycle.
- WAIT: on mem_rvalid, register mem_rdata into the owner's rdata and pulse the owner's rvalid on the next cycle; go to IDLE.
- Non-owner rdata holds its last value.
- mem_rvalid outside WAIT is ignored.
- Minimum turnaround: grant cycle + 1 REQ cycle + memory latency + 1 return cycle. The next grant is possible in the cycle after returning to IDLE.
- Starve counter:
  - Increments on each DM grant while if_req=1.
  - Clears on an IF grant or when if_req=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- Store lanes (big-endian):
  - SB: we=4'b1000>>addr[1:0]; wdata={4{b[7:0]}}.
  - SH: addr[0]=0 required; we=addr[1]?0011:1100; wdata={2{h[15:0]}}.
  - SW: addr[1:0]=00 required; we=1111.
  - Load: we=0000.
- Misaligned SH/SW: the transaction still issues with we=0000 (a harmless read); dm_err=1 with dm_rvalid.
- Simultaneous if_req and dm_req in IDLE: exactly one gnt per cycle; the loser keeps req and is served in a later IDLE.
- Request deasserted before gnt: dropped, no side effects.
- rst asserted mid-transaction: next cycle IDLE, outputs 0; the outstanding memory response is discarded.

Optional Feature:
- Macro MEM_ARB_PERF_EN, when defined:
  - Adds outputs perf_conflict (32, cycles in IDLE with both reqs high) and perf_if_wait (32, cycles with if_req high and no if_gnt).
  - Both counters clear on rst and wrap at 2^32.
- Undefined: no counters and no ports; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - State enum.
  - Size codes SZ_LOAD/SZ_BYTE/SZ_HALF/SZ_WORD (00/01/10/11).
  - Owner enum OWN_IF/OWN_DM.
- Sub-module store_lane_gen: combinational (size, addr[1:0], wdata) -> (we, wdata_rep, misalign); instantiated once.

Test Plan:
- Single fetch:
  - Stimulus: if_req, addr 0x100; mem_ready at first REQ cycle; mem_rvalid 2 cycles later with 0x2402000A.
  - Required: if_gnt at cycle 0; mem_req cycle 1 with mem_addr 0x100, we 0000; if_rvalid with 0x2402000A one cycle after mem_rvalid.
- Simultaneous requests:
  - Stimulus: if_req and dm_req together (dm load at 0x200).
  - Required: dm_gnt first, if_gnt at the next IDLE; mem_addr sequence 0x200 then 0x100.
- Store lanes:
  - SB addr 0x203, wdata 0xAB -> we 0001, wdata 0xABABABAB.
  - SH addr 0x202, wdata 0x1234 -> we 0011, wdata 0x12341234.
  - SW addr 0x204 -> we 1111.
  - SH addr 0x201 -> we 0000, dm_err=1.
- Starvation:
  - Stimulus: STARVE_LIMIT=4; dm_req and if_req held high continuously.
  - Required: DM granted 4 times, then IF granted; pattern repeats. With STARVE_LIMIT=0, IF is never granted.
- Backpressure and reset:
  - Stimulus: mem_ready low for 5 cycles.
  - Required: mem_req and payload stable for all 5 cycles.
  - Stimulus: assert rst in WAIT, then inject mem_rvalid.
  - Required: no rvalid pulse; state IDLE; all outputs 0.
- MEM_ARB_PERF_EN:
  - Stimulus: 3 conflict cycles.
  - Required: perf_conflict = 3; rst clears it to 0.
